// File: rtl/icache_req_skid_pkg.sv
// rtl/icache_req_skid_pkg.sv - shared state encoding for the icache request skid buffer
package icache_req_skid_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_BUSY  = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/dff_ar.sv
// rtl/dff_ar.sv - register with asynchronous active-low reset
module dff_ar #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_aren.sv
// rtl/dff_aren.sv - load-enable register with asynchronous active-low reset
module dff_aren #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/icache_req_skid.sv
// rtl/icache_req_skid.sv - registered fetch-request stage with one-entry skid and flush
module icache_req_skid
    import icache_req_skid_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    logic [1:0]            state_q;
    skid_state_e           state_d;
    logic                  out_en;
    logic                  skid_en;
    logic                  out_from_skid;
    logic [ADDR_WIDTH-1:0] out_d;
    logic [ADDR_WIDTH-1:0] out_q;
    logic [ADDR_WIDTH-1:0] skid_q;

    dff_ar #(.WIDTH(2)) u_state (
        .clk   (clock),
        .rst_n (reset),
        .d     (state_d),
        .q     (state_q)
    );

    dff_aren #(.WIDTH(ADDR_WIDTH)) u_out (
        .clk   (clock),
        .rst_n (reset),
        .en    (out_en),
        .d     (out_d),
        .q     (out_q)
    );

    dff_aren #(.WIDTH(ADDR_WIDTH)) u_skid (
        .clk   (clock),
        .rst_n (reset),
        .en    (skid_en),
        .d     (in_addr),
        .q     (skid_q)
    );

    assign out_d = out_from_skid ? skid_q : in_addr;

    // in_valid alone implies acceptance outside FULL: in_ready is only low there or under flush
    always_comb begin
        state_d       = SKID_EMPTY;
        out_en        = 1'b0;
        skid_en       = 1'b0;
        out_from_skid = 1'b0;
        if (!flush) begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_valid) begin
                        state_d = SKID_BUSY;
                        out_en  = 1'b1;
                    end else begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_BUSY: begin
                    if (in_valid && out_ready) begin
                        state_d = SKID_BUSY;
                        out_en  = 1'b1;
                    end else if (in_valid) begin
                        state_d = SKID_FULL;
                        skid_en = 1'b1;
                    end else if (out_ready) begin
                        state_d = SKID_EMPTY;
                    end else begin
                        state_d = SKID_BUSY;
                    end
                end
                SKID_FULL: begin
                    if (out_ready) begin
                        state_d       = SKID_BUSY;
                        out_en        = 1'b1;
                        out_from_skid = 1'b1;
                    end else begin
                        state_d = SKID_FULL;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // Handshakes depend only on registered state, flush and reset
    assign out_valid = (state_q != SKID_EMPTY) & ~flush;
    assign in_ready  = (state_q != SKID_FULL) & ~flush & reset;
    assign out_addr  = out_q;

endmodule

// File: tb/tb_icache_req_skid.sv
// tb/tb_icache_req_skid.sv - scoreboard bench for icache_req_skid
module tb_icache_req_skid;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;

    int          total = 0;
    int          bad = 0;
    int          occ = 0;
    int          n_before;
    bit          run = 1'b0;
    logic [31:0] sb[$];

    icache_req_skid #(.ADDR_WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit iv, input logic [31:0] a, input bit ordy, input bit fl);
        @(posedge clock);
        #1;
        in_valid  = iv;
        in_addr   = a;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Reference: a FIFO of capacity two, cleared by flush, one push/pop per cycle
    always @(negedge clock) begin
        if (run && reset) begin
            n_before = occ;
            chk("in_ready", in_ready, (n_before < 2) && !flush);
            chk("out_valid", out_valid, (n_before > 0) && !flush);
            if (flush) begin
                occ = 0;
                sb.delete();
            end else begin
                if (n_before > 0 && out_ready) occ--;
                if (in_valid && n_before < 2) begin
                    occ++;
                    sb.push_back(in_addr);
                end
            end
        end
    end

    // Monitor: every output transfer must match the oldest accepted request
    always @(negedge clock) begin
        if (run && reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_xfer: got addr %h want no transfer at %0t", out_addr, $time);
            end else begin
                chk("out_addr", out_addr, sb.pop_front());
            end
        end
    end

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_addr", out_addr, 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        run = 1'b1;

        // streaming
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // stall into skid then drain
        step(1'b1, 32'h200, 1'b1, 1'b0);
        step(1'b1, 32'h204, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        chk("skid_hold", out_addr, 32'h200);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // long stall with changing input
        step(1'b1, 32'h700, 1'b1, 1'b0);
        step(1'b1, 32'h704, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h800 + 32'(i * 4), 1'b0, 1'b0);
            @(negedge clock);
            chk("long_stall_hold", out_addr, 32'h700);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // flush while full
        step(1'b1, 32'h300, 1'b1, 1'b0);
        step(1'b1, 32'h304, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h400, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // flush with simultaneous request
        step(1'b1, 32'h500, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 25) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clock);
        chk("drained", sb.size(), 32'd0);

        // asynchronous reset while busy
        step(1'b1, 32'h600, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        #1;
        chk("busy_before_rst", out_valid, 1'b1);
        chk("busy_addr", out_addr, 32'h600);
        run = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_in_ready", in_ready, 1'b0);
        occ = 0;
        sb.delete();
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("rst2_out_addr", out_addr, 32'h0);
        chk("rst2_in_ready", in_ready, 1'b1);
        chk("rst2_out_valid", out_valid, 1'b0);
        run = 1'b1;
        step(1'b1, 32'h900, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clock);
        chk("final_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
